pipeline_hazard_sequencer: RTL

//  Registered hazard/stall controller for the 5-stage mips32 pipeline; replaces ad-hoc combinational hazard logic.

---
 rtl/pipeline_hazard_sequencer_if.sv | 38 +++
 rtl/pipeline_hazard_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard-controller bundle between the ID-stage neighbourhood and pipeline_hazard_sequencer.
// The master side drives the hazard inputs; the slave (the sequencer) returns the stall/flush controls.
interface pipeline_hazard_sequencer_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] idRs;
  logic [REG_W-1:0] idRt;
  logic             idUsesRt;
  logic [REG_W-1:0] exRt;
  logic             exMemRead;
  logic             idIsJump;
  logic             memJumpTaken;
  logic             memBranchTaken;
  logic             dmemReady;
  logic             memAccess;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             exMemFlush;
  logic             jumpStall;
  logic             pipeHold;
  logic             jumpErr;

  modport master (
    output idRs, idRt, idUsesRt, exRt, exMemRead, idIsJump,
           memJumpTaken, memBranchTaken, dmemReady, memAccess,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
           jumpStall, pipeHold, jumpErr
  );

  modport slave (
    input  idRs, idRt, idUsesRt, exRt, exMemRead, idIsJump,
           memJumpTaken, memBranchTaken, dmemReady, memAccess,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
           jumpStall, pipeHold, jumpErr
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage mips32 pipeline: load-use bubbles, jump waits, branch flushes, dmem freezes.
// Optional perf counters are enabled with the macro HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_sequencer #(
  parameter int REG_W        = 5,
  parameter int JUMP_TIMEOUT = 4
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  pipeline_hazard_sequencer_if.slave bus
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]          loadStallCnt,
  output logic [CNT_W-1:0]          jumpStallCnt,
  output logic [CNT_W-1:0]          memWaitCnt,
  output logic [CNT_W-1:0]          flushCnt
`endif
);

  localparam int JCNT_W = $clog2(JUMP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_JUMP_WAIT = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_eff_state;
  state_t            w_next_state;
  logic              r_ret_jw;
  logic              w_next_ret_jw;
  logic [JCNT_W-1:0] r_jcnt;
  logic [JCNT_W-1:0] w_next_jcnt;

  logic w_load_use;
  logic w_mem_wait;
  logic w_ev_load_use;
  logic w_ev_flush;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;
  logic w_jump_stall;
  logic w_pipe_hold;
  logic w_jump_err;

  // Next-state and control decode; a released MEM_WAIT behaves as the state it interrupted.
  always_comb begin
    w_load_use = bus.exMemRead && (bus.exRt != {REG_W{1'b0}}) &&
                 ((bus.idRs == bus.exRt) || (bus.idUsesRt && (bus.idRt == bus.exRt)));
    w_mem_wait = bus.memAccess && !bus.dmemReady;

    if ((r_state == ST_MEM_WAIT) && bus.dmemReady) begin
      w_eff_state = r_ret_jw ? ST_JUMP_WAIT : ST_RUN;
    end else begin
      w_eff_state = r_state;
    end

    w_next_state   = w_eff_state;
    w_next_jcnt    = r_jcnt;
    w_next_ret_jw  = r_ret_jw;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_jump_stall   = 1'b0;
    w_pipe_hold    = 1'b0;
    w_jump_err     = 1'b0;
    w_ev_load_use  = 1'b0;
    w_ev_flush     = 1'b0;

    case (w_eff_state)
      ST_MEM_WAIT: begin
        w_pipe_hold   = 1'b1;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
      end
      ST_RUN: begin
        if (w_mem_wait) begin
          w_pipe_hold   = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_next_state  = ST_MEM_WAIT;
          w_next_ret_jw = 1'b0;
        end else if (bus.memBranchTaken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
          w_ex_mem_flush = 1'b1;
          w_ev_flush     = 1'b1;
        end else if (bus.idIsJump) begin
          // memJumpTaken has no pending jump to resolve in RUN, so it is not examined here.
          w_pc_write   = 1'b0;
          w_jump_stall = 1'b1;
          w_next_state = ST_JUMP_WAIT;
          w_next_jcnt  = JCNT_W'(1);
        end else if (w_load_use) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
          w_ev_load_use = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_JUMP_WAIT: begin
        if (w_mem_wait) begin
          w_pipe_hold   = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_next_state  = ST_MEM_WAIT;
          w_next_ret_jw = 1'b1;
        end else if (bus.memBranchTaken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
          w_ex_mem_flush = 1'b1;
          w_ev_flush     = 1'b1;
          w_next_state   = ST_RUN;
          w_next_jcnt    = {JCNT_W{1'b0}};
        end else if (bus.memJumpTaken) begin
          w_if_id_flush = 1'b1;
          w_next_state  = ST_RUN;
          w_next_jcnt   = {JCNT_W{1'b0}};
        end else if (r_jcnt == JCNT_W'(JUMP_TIMEOUT)) begin
          w_jump_err   = 1'b1;
          w_next_state = ST_RUN;
          w_next_jcnt  = {JCNT_W{1'b0}};
        end else begin
          w_pc_write   = 1'b0;
          w_jump_stall = 1'b1;
          w_next_jcnt  = r_jcnt + JCNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_jcnt  = {JCNT_W{1'b0}};
      end
    endcase

    if (reset) begin
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_jump_stall   = 1'b0;
      w_pipe_hold    = 1'b0;
      w_jump_err     = 1'b0;
      w_ev_load_use  = 1'b0;
      w_ev_flush     = 1'b0;
    end else begin
      w_next_ret_jw = w_next_ret_jw;
    end
  end

  // State, jump-age counter and MEM_WAIT return point.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_jcnt   <= {JCNT_W{1'b0}};
      r_ret_jw <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_jcnt   <= w_next_jcnt;
      r_ret_jw <= w_next_ret_jw;
    end
  end

  assign bus.pcWrite    = w_pc_write;
  assign bus.ifIdWrite  = w_if_id_write;
  assign bus.ifIdFlush  = w_if_id_flush;
  assign bus.idExFlush  = w_id_ex_flush;
  assign bus.exMemFlush = w_ex_mem_flush;
  assign bus.jumpStall  = w_jump_stall;
  assign bus.pipeHold   = w_pipe_hold;
  assign bus.jumpErr    = w_jump_err;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_load_stall_cnt;
  logic [CNT_W-1:0] r_jump_stall_cnt;
  logic [CNT_W-1:0] r_mem_wait_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_stall_cnt <= {CNT_W{1'b0}};
      r_jump_stall_cnt <= {CNT_W{1'b0}};
      r_mem_wait_cnt   <= {CNT_W{1'b0}};
      r_flush_cnt      <= {CNT_W{1'b0}};
    end else begin
      r_load_stall_cnt <= sat_inc(r_load_stall_cnt, w_ev_load_use);
      r_jump_stall_cnt <= sat_inc(r_jump_stall_cnt, r_state == ST_JUMP_WAIT);
      r_mem_wait_cnt   <= sat_inc(r_mem_wait_cnt, r_state == ST_MEM_WAIT);
      r_flush_cnt      <= sat_inc(r_flush_cnt, w_ev_flush);
    end
  end

  assign loadStallCnt = r_load_stall_cnt;
  assign jumpStallCnt = r_jump_stall_cnt;
  assign memWaitCnt   = r_mem_wait_cnt;
  assign flushCnt     = r_flush_cnt;
`endif

endmodule
